dl_sample_detect: RTL and testbench

- Downstream consumer of the gate-level D latch outputs Q/Qb; brings them into the clk domain.
- Generates edge pulses, a shift history and a rising-edge count.
- Runs a "1011" overlapping sequence detector on the sampled stream.
- Flags illegal latch output states (Q == Qb) for lab checkout.

---
 rtl/dl_sample_detect.sv | 155 +++++++++++++++
 tb/tb_dl_sample_detect.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_sample_detect.sv
// dl_sample_detect: brings the D latch Q/Qb outputs into the clk domain and
// derives edge pulses, a sampled history, a "1011" overlapping sequence
// detector, a saturating rising-edge count and a sticky illegal-state flag.
//
// There is no valid/ready handshake here. Every output is a registered
// value, or a combinational function of registers, that is valid in every
// clk cycle after reset. Consumers sample them on any clk edge.
//
// SHIFT_W must be at least 4 so the history can hold one full "1011" window.
module dl_sample_detect #(
  parameter int SHIFT_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               q_in,
  input  logic               qb_in,
  input  logic               en,
  input  logic               clr,
  output logic               q_sync,
  output logic               rise,
  output logic               fall,
  output logic [SHIFT_W-1:0] shift_out,
  output logic               match,
  output logic [CNT_W-1:0]   edge_cnt,
  output logic               err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic   q_s1;
  logic   qb_s1;
  logic   qb_sync;
  logic   q_d;
  logic   eq_prev;
  logic   eq_now;
  state_t state;
  state_t state_nxt;
  logic   match_nxt;

  // Two-flop synchronizers on both latch outputs plus the one-cycle delay for
  // edge detection. The Qb chain resets to 1 so a reset latch reads as legal.
  // clr deliberately leaves this path alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1    <= 1'b0;
      q_sync  <= 1'b0;
      qb_s1   <= 1'b1;
      qb_sync <= 1'b1;
      q_d     <= 1'b0;
    end else begin
      q_s1    <= q_in;
      q_sync  <= q_s1;
      qb_s1   <= qb_in;
      qb_sync <= qb_s1;
      q_d     <= q_sync;
    end
  end

  // Edge pulses come straight from registers, so each lasts exactly one cycle.
  always_comb begin
    rise = q_sync & ~q_d;
    fall = ~q_sync & q_d;
  end

  // Sampled history: the newest q_sync value enters at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_out <= '0;
    end else if (clr) begin
      shift_out <= '0;
    end else if (en) begin
      shift_out <= {shift_out[SHIFT_W-2:0], q_sync};
    end
  end

  // Detector state and registered match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
    end
  end

  // Overlapping "1011" transitions. Each state is the longest prefix of the
  // pattern that is also a suffix of the accepted bits. match is raised only
  // when the completing 1 is accepted. With en low the state holds and match
  // drops.
  always_comb begin
    state_nxt = state;
    match_nxt = 1'b0;
    if (clr) begin
      state_nxt = S0;
    end else if (en) begin
      case (state)
        S0:   state_nxt = q_sync ? S1 : S0;
        S1:   state_nxt = q_sync ? S1 : S10;
        S10:  state_nxt = q_sync ? S101 : S0;
        S101: begin
          if (q_sync) begin
            state_nxt = S1;
            match_nxt = 1'b1;
          end else begin
            state_nxt = S10;
          end
        end
        default: state_nxt = S0;
      endcase
    end
  end

  assign state_dbg = state;

  // Saturating count of rise pulses. It counts regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
    end else if (rise && (edge_cnt != CNT_MAX)) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign eq_now = (q_sync == qb_sync);

  // Illegal-state flag. Q==Qb must persist across two consecutive edges,
  // so the one-cycle skew of a normal latch transition is ignored.
  // eq_prev is a history bit and is not cleared by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_prev <= 1'b0;
      err     <= 1'b0;
    end else begin
      eq_prev <= eq_now;
      if (clr) begin
        err <= 1'b0;
      end else if (eq_now && eq_prev) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dl_sample_detect.sv
// tb_dl_sample_detect: directed and randomized stimulus for dl_sample_detect.
// The reference model keeps the raw input history and derives each output
// from the behavioural rules:
//   - q_sync shows the q_in value sampled two edges earlier.
//   - The history is the list of accepted q_sync samples.
//   - match means the last four accepted samples read 1011.
//   - The counter is min(rises since clr, max).
//   - err means Q==Qb held across two consecutive edges.
module tb_dl_sample_detect;
  localparam int SHIFT_W = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int W       = 3 + SHIFT_W + 1 + CNT_W + 1;

  typedef struct packed {
    logic               q_sync;
    logic               rise;
    logic               fall;
    logic [SHIFT_W-1:0] shift;
    logic               match;
    logic [CNT_W-1:0]   cnt;
    logic               err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               q_in;
  logic               qb_in;
  logic               en;
  logic               clr;
  logic               q_sync;
  logic               rise;
  logic               fall;
  logic [SHIFT_W-1:0] shift_out;
  logic               match;
  logic [CNT_W-1:0]   edge_cnt;
  logic               err;
  logic [1:0]         state_dbg;

  logic [W-1:0] exp_q[$];
  bit           qh[$];
  bit           qbh[$];
  logic [SHIFT_W-1:0] m_shift;
  int           m_cnt;
  bit           m_err;
  int           checks = 0;
  int           errors = 0;

  dl_sample_detect #(.SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .qb_in(qb_in), .en(en), .clr(clr),
    .q_sync(q_sync), .rise(rise), .fall(fall), .shift_out(shift_out),
    .match(match), .edge_cnt(edge_cnt), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_q_sync", q_sync, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_shift", shift_out, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", edge_cnt, 0);
    chk("rst_err", err, 0);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    qh = {1'b0, 1'b0, 1'b0};
    qbh = {1'b1, 1'b1, 1'b1};
    m_shift = '0;
    m_cnt = 0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  // Called right at a rising edge with the inputs that edge sampled.
  // After the push: qh[3] was sampled now, qh[2] is q_sync after this edge,
  // qh[1] is q_sync before this edge, and qh[0] is q_sync one edge earlier.
  task automatic model_edge();
    bit   rise_before;
    bit   eq_cond;
    bit   m_match;
    exp_t e;
    qh.push_back(q_in);
    qbh.push_back(qb_in);
    while (qh.size() > 4) void'(qh.pop_front());
    while (qbh.size() > 4) void'(qbh.pop_front());
    rise_before = qh[1] & ~qh[0];
    eq_cond = (qh[1] == qbh[1]) && (qh[0] == qbh[0]);
    m_match = 1'b0;
    if (clr) begin
      m_shift = '0;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (en) begin
        m_shift = {m_shift[SHIFT_W-2:0], qh[1]};
        m_match = (m_shift[3:0] == 4'b1011);
      end
      if (rise_before && m_cnt < CNT_MAX) m_cnt++;
      if (eq_cond) m_err = 1'b1;
    end
    e.q_sync = qh[2];
    e.rise   = qh[2] & ~qh[1];
    e.fall   = ~qh[2] & qh[1];
    e.shift  = m_shift;
    e.match  = m_match;
    e.cnt    = CNT_W'(m_cnt);
    e.err    = m_err;
    exp_q.push_back(W'(e));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit q, input bit qb, input bit e, input bit c);
    q_in = q;
    qb_in = qb;
    en = e;
    clr = c;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    q_in = 1'b0;
    qb_in = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("q_sync", q_sync, e.q_sync);
      chk("rise", rise, e.rise);
      chk("fall", fall, e.fall);
      chk("shift_out", shift_out, e.shift);
      chk("match", match, e.match);
      chk("edge_cnt", edge_cnt, e.cnt);
      chk("err", err, e.err);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] qv;
    logic [10:0] ev;
    bit          q;
    rst_n = 1'b0;
    q_in = 1'b0;
    qb_in = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    model_reset();
    #3;
    chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // First sample after reset: q_in goes high and a single rise follows.
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Stream containing 1011011 with en held high.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    qv = 11'b11011010000;
    for (int i = 0; i < 11; i++) cyc(qv[i], ~qv[i], 1'b1, 1'b0);

    // 30 rising edges, so the counter must saturate.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Illegal-state flag: a one-cycle overlap is ignored,
    // a three-cycle overlap sticks until clr.
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // en dropped for 5 cycles after "101", then one more 1 completes the match.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    qv = 11'b11111111101;
    ev = 11'b10000011100;
    for (int i = 0; i < 11; i++) cyc(qv[i], ~qv[i], ev[i], 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);

    // clr on the same edge as en=1 and rise=1.
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a pattern.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with occasional illegal states and clears.
    for (int i = 0; i < 400; i++) begin
      q = 1'($urandom_range(0, 1));
      cyc(q, ($urandom_range(0, 5) == 0) ? q : ~q,
          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
